cu_next_state: RTL and testbench

//  Next-state logic of the multicycle control unit (MIPS-style FSM).
//  - Combinational: maps the current FSM state and the instruction opcode to the next state.
//  - Also provides a registered copy of the next state and an illegal-condition flag.
//  - Sits between the CU state register and the CU output decoder.

---
 rtl/cu_next_state_if.sv | 37 +++
 rtl/cu_next_state.sv | 101 ++++++++++
 tb/tb_cu_next_state.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cu_next_state_if.sv
// -----------------------------------------------------------------------------
// cu_next_state_if
//   Bundles the signals between the multicycle CU state register / output
//   decoder and the next-state block.
//   op       6  instruction opcode field          (master -> slave)
//   state    4  current FSM state                 (master -> slave)
//   ns       4  next state, combinational         (slave -> master)
//   ns_r     4  next state registered on clk      (slave -> master)
//   illegal  1  undefined opcode in DECODE or state >= 10 (slave -> master)
//   ill_seen 1  sticky registered copy of illegal (slave -> master)
// -----------------------------------------------------------------------------
interface cu_next_state_if;
  logic [5:0] op;
  logic [3:0] state;
  logic [3:0] ns;
  logic [3:0] ns_r;
  logic       illegal;
  logic       ill_seen;

  modport master (
    output op,
    output state,
    input  ns,
    input  ns_r,
    input  illegal,
    input  ill_seen
  );

  modport slave (
    input  op,
    input  state,
    output ns,
    output ns_r,
    output illegal,
    output ill_seen
  );
endinterface

// File: rtl/cu_next_state.sv
// -----------------------------------------------------------------------------
// cu_next_state
//   Next-state logic of the multicycle (MIPS-style) control unit FSM.
//   Maps {state, op} combinationally to the next state, flags illegal
//   conditions, and provides registered copies of both.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (clears ns_r and ill_seen only)
//     bus    cu_next_state_if.slave : op, state in; ns, ns_r, illegal,
//            ill_seen out
//
//   Configuration macro: NEXT_STATE_ILLEGAL_TRAP_EN
//     Defined  : every illegal condition steers ns to TRAP (4'b1111); TRAP
//                maps to itself, so only rst_n leaves it.
//     Undefined: illegal conditions steer ns to FETCH.
// -----------------------------------------------------------------------------
module cu_next_state (
  input  logic                  clk,
  input  logic                  rst_n,
  cu_next_state_if.slave        bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef NEXT_STATE_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP   = 4'd15;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] ns_c;
  logic       ill_c;
  logic [3:0] ns_q;
  logic       ill_seen_q;

  // Stage 0: combinational next-state decode. op is only examined inside the
  // DECODE and MEMADR arms so an unknown op elsewhere cannot reach ns.
  always_comb begin
    ns_c  = S_FETCH;
    ill_c = 1'b0;
    case (bus.state)
      S_FETCH:  ns_c = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_RTYPE:     ns_c = S_EXEC;
          OP_LW, OP_SW: ns_c = S_MEMADR;
          OP_BEQ:       ns_c = S_BRANCH;
          OP_J:         ns_c = S_JUMP;
          default:      ill_c = 1'b1;
        endcase
      end
      // A non-memory op here just returns to FETCH; it is not flagged.
      S_MEMADR: begin
        case (bus.op)
          OP_LW:   ns_c = S_MEMRD;
          OP_SW:   ns_c = S_MEMWR;
          default: ns_c = S_FETCH;
        endcase
      end
      S_MEMRD:  ns_c = S_MEMWB;
      S_EXEC:   ns_c = S_ALUWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: ns_c = S_FETCH;
      default:  ill_c = 1'b1;   // unused codes 10..15
    endcase
`ifdef NEXT_STATE_ILLEGAL_TRAP_EN
    // TRAP (15) is itself an unused code, so it self-loops through this path.
    if (ill_c) ns_c = S_TRAP;
`endif
  end

  assign bus.ns      = ns_c;
  assign bus.illegal = ill_c;

  // Stage 1: registered next state and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_q       <= S_FETCH;
      ill_seen_q <= 1'b0;
    end else begin
      ns_q       <= ns_c;
      ill_seen_q <= ill_seen_q | ill_c;
    end
  end

  assign bus.ns_r     = ns_q;
  assign bus.ill_seen = ill_seen_q;

endmodule

// File: tb/tb_cu_next_state.sv
module tb_cu_next_state;

  logic clk;
  logic rst_n;

  cu_next_state_if bus ();

  cu_next_state dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ns;
    logic       ill;
  } exp_t;

  exp_t q_comb[$];
  exp_t q_reg[$];
  logic model_seen;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference table written from the state diagram.
  function automatic exp_t model(input logic [3:0] s, input logic [5:0] o);
    exp_t e;
    e.ns  = 4'd0;
    e.ill = 1'b0;
    if (s >= 4'd10) e.ill = 1'b1;
    else if (s == 4'd0) e.ns = 4'd1;
    else if (s == 4'd1) begin
      if (o == 6'b000000)      e.ns = 4'd6;
      else if (o == 6'b100011) e.ns = 4'd2;
      else if (o == 6'b101011) e.ns = 4'd2;
      else if (o == 6'b000100) e.ns = 4'd8;
      else if (o == 6'b000010) e.ns = 4'd9;
      else                     e.ill = 1'b1;
    end else if (s == 4'd2) begin
      if (o == 6'b100011)      e.ns = 4'd3;
      else if (o == 6'b101011) e.ns = 4'd5;
    end else if (s == 4'd3) e.ns = 4'd4;
    else if (s == 4'd6) e.ns = 4'd7;
`ifdef NEXT_STATE_ILLEGAL_TRAP_EN
    if (e.ill) e.ns = 4'd15;
`endif
    return e;
  endfunction

  task automatic apply(input logic [3:0] s, input logic [5:0] o, input logic [5:0] o_model,
                       input string tag);
    exp_t e;
    @(negedge clk);
    bus.state = s;
    bus.op    = o;
    e = model(s, o_model);
    q_comb.push_back(e);
    q_reg.push_back(e);
    #1;
    if (q_comb.size() == 0) chk({tag, "_qempty"}, 1, 0);
    else begin
      e = q_comb.pop_front();
      chk({tag, "_ns"}, 32'(bus.ns), 32'(e.ns));
      chk({tag, "_ill"}, 32'(bus.illegal), 32'(e.ill));
    end
    @(posedge clk);
    #1;
    if (q_reg.size() == 0) chk({tag, "_rqempty"}, 1, 0);
    else begin
      e = q_reg.pop_front();
      model_seen = model_seen | e.ill;
      chk({tag, "_ns_r"}, 32'(bus.ns_r), 32'(e.ns));
      chk({tag, "_ill_seen"}, 32'(bus.ill_seen), 32'(model_seen));
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_seen = 1'b0;
    rst_n      = 1'b0;
    bus.state  = 4'd0;
    bus.op     = 6'd0;
    #12;
    chk("rst_ns_r", 32'(bus.ns_r), 0);
    chk("rst_ill_seen", 32'(bus.ill_seen), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases; op is X where it must be ignored.
    apply(4'd0, 6'bxxxxxx, 6'd0, "fetch_opx");
    apply(4'd3, 6'bxxxxxx, 6'd0, "memrd_opx");
    apply(4'd6, 6'bxxxxxx, 6'd0, "exec_opx");
    for (int s = 4; s <= 9; s++)
      if (s != 6) apply(4'(s), 6'b111111, 6'b111111, $sformatf("to_fetch_s%0d", s));
    apply(4'd1, 6'b000010, 6'b000010, "dec_j");
    apply(4'd1, 6'b000100, 6'b000100, "dec_beq");
    apply(4'd1, 6'b000000, 6'b000000, "dec_rtype");
    apply(4'd1, 6'b100011, 6'b100011, "dec_lw");
    apply(4'd1, 6'b101011, 6'b101011, "dec_sw");
    apply(4'd2, 6'b100011, 6'b100011, "madr_lw");
    apply(4'd2, 6'b101011, 6'b101011, "madr_sw");
    apply(4'd2, 6'b000000, 6'b000000, "madr_rtype");
    apply(4'd1, 6'b111111, 6'b111111, "dec_illegal");

    // Reset asserted between edges clears registers at once.
    apply(4'd3, 6'd0, 6'd0, "pre_rst");
    #2;
    rst_n = 1'b0;
    model_seen = 1'b0;
    #1;
    chk("mid_rst_ns_r", 32'(bus.ns_r), 0);
    chk("mid_rst_ill_seen", 32'(bus.ill_seen), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep.
    for (int s = 0; s < 16; s++)
      for (int o = 0; o < 64; o++)
        apply(4'(s), 6'(o), 6'(o), $sformatf("sweep_s%0d_o%0d", s, o));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
